// File: rtl/sub_seq.sv
// Multi-cycle WIDTH-bit subtractor: one CHUNK-bit slice per clock, borrow rippled between slices.
// Optional build macro SUB_SEQ_SAT_EN: saturate the result to zero when the final borrow is set.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | subtracting chunk idx, busy=1
// DONE  | one-cycle done pulse, result valid
module sub_seq #(
  parameter int WIDTH = 1024,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [IDX_W-1:0] idx;
  logic             borrow;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   diff;

  always_comb begin
    a_chunk = a_op[idx*CHUNK +: CHUNK];
    b_chunk = b_op[idx*CHUNK +: CHUNK];
    diff    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out        <= '0;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      idx        <= '0;
      borrow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_op   <= in1;
            b_op   <= in2;
            borrow <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          out[idx*CHUNK +: CHUNK] <= diff[CHUNK-1:0];
          borrow <= diff[CHUNK];
          if (idx == IDX_LAST) begin
            borrow_out <= diff[CHUNK];
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
`ifdef SUB_SEQ_SAT_EN
            // Saturating mode: an underflow clamps the whole result to zero.
            if (diff[CHUNK]) out <= '0;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_seq.sv
// Scoreboard bench for sub_seq: expected results queued at start, compared on each done pulse.
module tb_sub_seq;

  localparam int W = 1024;
  localparam int C = 32;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in1, in2;
  logic [W-1:0] out;
  logic         borrow_out, busy, done;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb_q[$];

  sub_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .out(out), .borrow_out(borrow_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got(low128)=%h want(low128)=%h diff_hi=%0d", tag, obs[127:0], exp[127:0],
               (obs[W:128] !== exp[W:128]));
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b};
`ifdef SUB_SEQ_SAT_EN
    if (r[W]) r[W-1:0] = '0;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard side: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      chk("busy_with_done", {{W{1'b0}}, busy}, '0);
      if (sb_q.size() == 0) begin
        chk("spurious_done", {{W{1'b0}}, done}, '0);
      end else begin
        logic [W:0] e;
        e = sb_q.pop_front();
        chk("out", {1'b0, out}, {1'b0, e[W-1:0]});
        chk("borrow_out", {{W{1'b0}}, borrow_out}, {{W{1'b0}}, e[W]});
      end
    end
  end

  // mode 0: normal, 1: start held and operands scrambled during RUN, 2: reset at chunk 10
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                        input bit timed);
    int cyc = 0;
    int nbusy = 0;
    bit seen = 0;
    logic [W:0] e;
    e = model(a, b);
    sb_q.push_back(e);
    start = 1'b1;
    in1 = a;
    in2 = b;
    while (!seen && cyc < N + 10) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) begin
        in1 = rand_w();
        in2 = rand_w();
      end else begin
        start = 1'b0;
      end
      if (busy) nbusy++;
      if (done) seen = 1;
      if (mode == 2 && cyc == 11) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {{W{1'b0}}, busy}, '0);
        chk("abort_done", {{W{1'b0}}, done}, '0);
        chk("abort_out", {1'b0, out}, '0);
        chk("abort_borrow", {{W{1'b0}}, borrow_out}, '0);
        void'(sb_q.pop_back());
        repeat (N + 5) @(negedge clk);
        return;
      end
    end
    if (timed) begin
      chk("latency", W'(cyc), W'(N + 1));
      chk("busy_cycles", W'(nbusy), W'(N));
    end else if (!seen) begin
      chk("done_timeout", W'(cyc), W'(N + 1));
    end
    @(negedge clk);
    if (mode == 1) begin
      chk("no_accept_in_done", {{W{1'b0}}, busy}, '0);
      start = 1'b0;
    end
    if (timed) chk("out_hold", {1'b0, out}, {1'b0, e[W-1:0]});
  endtask

  initial begin
    logic [W-1:0] x, y;
    rst = 1'b1;
    start = 1'b1;
    in1 = W'(5);
    in2 = W'(3);
    repeat (3) @(negedge clk);
    chk("rst_busy", {{W{1'b0}}, busy}, '0);
    chk("rst_done", {{W{1'b0}}, done}, '0);
    chk("rst_out", {1'b0, out}, '0);
    chk("rst_borrow", {{W{1'b0}}, borrow_out}, '0);
    rst = 1'b0;
    run_op(W'(5), W'(3), 0, 1);

    run_op('0, W'(1), 0, 1);
    x = '0;
    x[32] = 1'b1;
    run_op(x, W'(1), 0, 1);
    run_op('1, '1, 0, 1);
    x = rand_w();
    run_op(x, x, 0, 1);

    run_op(rand_w(), rand_w(), 1, 1);
    run_op(rand_w(), rand_w(), 2, 0);
    run_op(W'(7), W'(9), 0, 1);

    for (int i = 0; i < 1000; i++) begin
      x = rand_w();
      y = (i % 50 == 0) ? x : rand_w();
      run_op(x, y, 0, 0);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", W'(sb_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
